// File: rtl/norm_seq.sv
// norm_seq: runs N(d1) and then N(d2) through one shared normal-CDF core.
// It derives the put-side terms N(-d) = 1 - N(d) and flags a hung core
// through a per-wait watchdog.
module norm_seq #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             busy,
    output logic [WIDTH-1:0] Nd1,
    output logic [WIDTH-1:0] Nd2,
    output logic [WIDTH-1:0] Nmd1,
    output logic [WIDTH-1:0] Nmd2,
    output logic             done,
    output logic             err,
    output logic             core_start,
    output logic [WIDTH-1:0] core_d,
    input  logic [WIDTH-1:0] core_N,
    input  logic             core_done
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(65536);

    typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FIN} state_t;

    state_t                  state, state_nx;
    logic [WIDTH-1:0]        op1, op2;
    logic [CW-1:0]           cnt;
    logic                    cnt_term;
    logic signed [WIDTH-1:0] n_s;
    logic [WIDTH-1:0]        clamped;

    assign n_s      = core_N;
    assign cnt_term = (cnt == CW'(TIMEOUT - 1));

    // The operand is steered by phase. op1 and op2 only change when a new
    // job is accepted, so core_d stays stable across each core request.
    assign core_d = (state == ISSUE2 || state == WAIT2) ? op2 : op1;

    // Saturate the core result into [0, 1.0] so that 1 - N cannot overflow.
    always_comb begin
        clamped = core_N;
        if (n_s < 0)
            clamped = '0;
        else if (n_s > ONE)
            clamped = ONE;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic and the core request pulse
    always_comb begin
        state_nx   = state;
        core_start = 1'b0;
        case (state)
            IDLE, FIN: if (start) state_nx = ISSUE1;
            ISSUE1: begin
                core_start = 1'b1;
                state_nx   = WAIT1;
            end
            WAIT1:  if (core_done || cnt_term) state_nx = ISSUE2;
            ISSUE2: begin
                core_start = 1'b1;
                state_nx   = WAIT2;
            end
            WAIT2:  if (core_done || cnt_term) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, watchdog counter, result capture and status flags.
    // A core_done in the same cycle as the terminal count is taken as a
    // result, so err is not set in that case.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op1  <= '0;
            op2  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            Nd1  <= '0;
            Nd2  <= '0;
            Nmd1 <= '0;
            Nmd2 <= '0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        op1  <= d1;
                        op2  <= d2;
                        busy <= 1'b1;
                        done <= 1'b0;
                        err  <= 1'b0;
                    end
                end
                ISSUE1, ISSUE2: cnt <= '0;
                WAIT1: begin
                    if (core_done) begin
                        Nd1  <= clamped;
                        Nmd1 <= ONE - clamped;
                    end else if (cnt_term) begin
                        Nd1  <= '0;
                        Nmd1 <= ONE;
                        err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT2: begin
                    if (core_done) begin
                        Nd2  <= clamped;
                        Nmd2 <= ONE - clamped;
                    end else if (cnt_term) begin
                        Nd2  <= '0;
                        Nmd2 <= ONE;
                        err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (core_done || cnt_term) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/norm_seq.md
Name: norm_seq

Overview:
- Sequencer that time-shares one normal-CDF core (norm_single-style start/d/N/done interface) between the two Black-Scholes operands d1 and d2.
- Replaces the dual-core norm block where area matters.
- Computes N(d1), then N(d2), then derives the put-side terms N(-d1) = 1 - N(d1) and N(-d2) = 1 - N(d2).
- Includes a watchdog for a hung core.

Parameters:
- WIDTH, 32, data width; all values are signed Q16.16.
- TIMEOUT, 256, maximum cycles in a wait state before the core is declared hung (must be >= 2).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request pulse; captures d1 and d2
- d1  input  WIDTH  signed Q16.16 operand
- d2  input  WIDTH  signed Q16.16 operand
- busy  output  1  high from accepted start until done rises
- Nd1  output  WIDTH  N(d1), Q16.16
- Nd2  output  WIDTH  N(d2), Q16.16
- Nmd1  output  WIDTH  N(-d1) = 0x00010000 - Nd1
- Nmd2  output  WIDTH  N(-d2) = 0x00010000 - Nd2
- done  output  1  level; high when results are valid, held until the next accepted start
- err  output  1  level; core timeout occurred in the current job, held until the next accepted start
- core_start  output  1  one-cycle pulse to the shared core
- core_d  output  WIDTH  operand to the core; held stable from core_start until core_done
- core_N  input  WIDTH  core result, valid while core_done is high
- core_done  input  1  core completion; the core must drop it no later than the cycle after it samples core_start

Behaviour:
- Reset (asynchronous, immediate): state=IDLE.
  - busy, done, err, core_start = 0.
  - Nd1, Nd2, Nmd1, Nmd2, core_d = 0.
  - Internal operand registers and timeout counter = 0.
  - Reset mid-job abandons the job. No core_start is issued afterwards. A core_done arriving later is ignored, because the state is IDLE.
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, FIN.
- IDLE/FIN, start=1:
  - Latch d1 and d2; clear done and err; set busy.
  - Go to ISSUE1.
  - Nd*/Nmd* keep their old values until overwritten.
- start while busy (ISSUE*/WAIT*) is ignored, with no latch and no effect.
- ISSUE1:
  - core_start=1 and core_d=d1 latch for exactly this cycle.
  - Clear the timeout counter; go to WAIT1.
- WAIT1:
  - core_start=0 and core_d held.
  - On core_done=1: capture Nd1 = clamp(core_N) and go to ISSUE2.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no done: Nd1=0, err=1, go to ISSUE2. The second operand is still attempted.
- ISSUE2/WAIT2: same as ISSUE1/WAIT1, using the d2 latch and Nd2.
  - Exit goes to FIN.
  - In FIN: busy=0 and done=1.
- Clamp: values < 0 become 0; values > 0x00010000 become 0x00010000; otherwise pass through.
- Nmd1/Nmd2 are registered and updated in the same cycle as Nd1/Nd2, from the clamped value. The result therefore always lies in [0, 0x00010000], with no overflow.
- core_done is sampled only in WAIT1/WAIT2. It is ignored in IDLE, ISSUE* and FIN, including a stale high left over from the previous job.
- core_done and the timeout terminal count in the same cycle: core_done wins and err is not set.
- Latency, with core latency L (core_done first high L cycles after the core samples core_start, L >= 1):
  - Start sampled at edge 0.
  - core_start is high in cycle 1.
  - Second core_start is high in cycle L+2.
  - done rises at cycle 2L+3.
  - busy falls on the same edge that done rises.
- Back-to-back: start in the same cycle that done is high (FIN) is accepted, and done drops the next cycle.

Test Plan:
1. Reset during WAIT1 (stub core L=4), then release -> all outputs 0, core_start stays 0, and a stale core_done pulse produces no state change.
2. Stub core L=4 returning 0x00008000 then 0x0000C000; start at edge 0 -> done rises at cycle 11; Nd1=0x00008000, Nd2=0x0000C000, Nmd1=0x00008000, Nmd2=0x00004000; err=0.
3. Stub core returning 0x00011000 then 0xFFFFF000 -> Nd1=0x00010000, Nmd1=0, Nd2=0, Nmd2=0x00010000.
4. Start pulses at cycles 3 and 5 during a job -> the second and third are ignored; results match the first operands; exactly two core_start pulses.
5. Core never asserts done, TIMEOUT=16 -> err=1, Nd1=Nd2=0, done rises after both waits expire. A following start clears err, and a good job then completes normally.
6. core_done held high from the previous job into ISSUE1 but dropped in WAIT1 -> not taken as a result; the correct new value is captured. Also cover start in the FIN cycle, which must restart with done dropping the next cycle.
